// File: rtl/serial_add_seq.sv
// serial_add_seq: bit-serial WIDTH-bit adder sequencer, one full-adder bit per clock, LSB first.
// Optional subtract mode is built in when SERIAL_ADD_SUB_EN is defined.
module serial_add_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             cin,
`ifdef SERIAL_ADD_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum_out,
  output logic             cout_out
);

  // state | meaning
  // IDLE  | waiting for start; sum_out/cout_out hold the last result
  // SHIFT | one operand bit pair added per edge, LSB first
  // DONE  | result valid for one cycle (done pulse)
  localparam int CNT_W = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             carry_q, carry_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [WIDTH-1:0] load_b;
  logic             load_carry;
  logic             bit_a, bit_b, bit_c, bit_sum, bit_carry;

`ifdef SERIAL_ADD_SUB_EN
  // Subtraction as a + ~b + 1: invert B once at load and force the carry-in.
  assign load_b     = sub ? ~b_in : b_in;
  assign load_carry = sub | cin;
`else
  assign load_b     = b_in;
  assign load_carry = cin;
`endif

  assign bit_a     = a_q[0];
  assign bit_b     = b_q[0];
  assign bit_c     = carry_q;
  assign bit_sum   = bit_a ^ bit_b ^ bit_c;
  assign bit_carry = (bit_a & bit_b) | (bit_a & bit_c) | (bit_b & bit_c);

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = a_in;
          b_d     = load_b;
          carry_d = load_carry;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        res_d   = {bit_sum, res_q[WIDTH-1:1]};
        a_d     = {1'b0, a_q[WIDTH-1:1]};
        b_d     = {1'b0, b_q[WIDTH-1:1]};
        carry_d = bit_carry;
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
    end
  end

  // All outputs come straight from flops.
  assign busy     = (state_q == SHIFT);
  assign done     = (state_q == DONE);
  assign sum_out  = res_q;
  assign cout_out = carry_q;

endmodule

// File: tb/tb_serial_add_seq.sv
// tb_serial_add_seq: directed and random checks of serial_add_seq (WIDTH=8) plus an exhaustive WIDTH=2 sweep.
// Subtract cases are exercised when SERIAL_ADD_SUB_EN is defined.
module tb_serial_add_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, start, cin, busy, done, cout_out;
  logic [7:0] a_in, b_in, sum_out;
  logic       start2, cin2, busy2, done2, cout2;
  logic [1:0] a2, b2, sum2;
`ifdef SERIAL_ADD_SUB_EN
  logic       sub, sub2;
`endif

  int checks = 0;
  int errors = 0;

  serial_add_seq #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .start(start), .a_in(a_in), .b_in(b_in), .cin(cin),
`ifdef SERIAL_ADD_SUB_EN
    .sub(sub),
`endif
    .busy(busy), .done(done), .sum_out(sum_out), .cout_out(cout_out)
  );

  serial_add_seq #(.WIDTH(2)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .a_in(a2), .b_in(b2), .cin(cin2),
`ifdef SERIAL_ADD_SUB_EN
    .sub(sub2),
`endif
    .busy(busy2), .done(done2), .sum_out(sum2), .cout_out(cout2)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One full 8-bit operation; expected value from plain arithmetic on the operands.
  task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic c, input logic s,
                      input string tag);
    logic [8:0] exp;
    logic [7:0] nb;
    nb  = ~b;
    exp = s ? ({1'b0, a} + {1'b0, nb} + 9'd1) : ({1'b0, a} + {1'b0, b} + {8'd0, c});
    @(negedge clk);
    start = 1'b1; a_in = a; b_in = b; cin = c;
`ifdef SERIAL_ADD_SUB_EN
    sub = s;
`endif
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; a_in = 8'($urandom); b_in = 8'($urandom); cin = 1'($urandom);
`ifdef SERIAL_ADD_SUB_EN
    sub = ~s;
`endif
    chk({tag, " busy/done first"}, {busy, done}, 2'b10);
    for (int i = 1; i < 8; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk({tag, " busy/done shift"}, {busy, done}, 2'b10);
    end
    @(posedge clk);
    @(negedge clk);
    chk({tag, " busy/done at done"}, {busy, done}, 2'b01);
    chk({tag, " cout/sum"}, {cout_out, sum_out}, exp);
    @(posedge clk);
    @(negedge clk);
    chk({tag, " idle busy/done"}, {busy, done}, 2'b00);
    chk({tag, " result hold"}, {cout_out, sum_out}, exp);
  endtask

  initial begin
    logic seen;
    rst = 1'b1; start = 1'b0; a_in = '0; b_in = '0; cin = 1'b0;
    start2 = 1'b0; a2 = '0; b2 = '0; cin2 = 1'b0;
`ifdef SERIAL_ADD_SUB_EN
    sub = 1'b0; sub2 = 1'b0;
`endif
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset outputs", {busy, done, cout_out, sum_out}, 11'd0);
    chk("reset outputs w2", {busy2, done2, cout2, sum2}, 5'd0);
    rst = 1'b0;

    run8(8'h25, 8'h17, 1'b0, 1'b0, "add 25+17");
    run8(8'hFF, 8'h01, 1'b0, 1'b0, "add FF+01");
    run8(8'h00, 8'h00, 1'b1, 1'b0, "add 00+00+1");

    // start held high through SHIFT and DONE: ignored until the first IDLE edge
    @(negedge clk);
    start = 1'b1; a_in = 8'h0F; b_in = 8'h01; cin = 1'b0;
    @(posedge clk);
    @(negedge clk);
    a_in = 8'h33; b_in = 8'h44;
    repeat (8) @(posedge clk);
    @(negedge clk);
    chk("held start done", {busy, done}, 2'b01);
    chk("held start result", {cout_out, sum_out}, 9'h010);
    @(posedge clk);
    @(negedge clk);
    chk("held start idle", {busy, done}, 2'b00);
    @(posedge clk);
    @(negedge clk);
    chk("held start reaccept", {busy, done}, 2'b10);
    start = 1'b0;
    repeat (8) @(posedge clk);
    @(negedge clk);
    chk("second op done", {busy, done}, 2'b01);
    chk("second op result", {cout_out, sum_out}, 9'h077);
    @(posedge clk);

    // reset on the 4th SHIFT edge discards the operation
    @(negedge clk);
    start = 1'b1; a_in = 8'hAA; b_in = 8'h55; cin = 1'b0;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("mid-shift reset outputs", {busy, done, cout_out, sum_out}, 11'd0);
    seen = 1'b0;
    repeat (12) begin
      @(posedge clk);
      @(negedge clk);
      seen = seen | done | busy;
    end
    chk("no done after reset", seen, 1'b0);

    // reset and start on the same edge: reset wins
    @(negedge clk);
    rst = 1'b1; start = 1'b1; a_in = 8'h01; b_in = 8'h01;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    chk("rst beats start", {busy, done}, 2'b00);
    @(posedge clk);
    @(negedge clk);
    chk("rst beats start stays idle", {busy, done}, 2'b00);

`ifdef SERIAL_ADD_SUB_EN
    run8(8'h10, 8'h01, 1'b0, 1'b1, "sub 10-01");
    run8(8'h01, 8'h02, 1'b1, 1'b1, "sub 01-02");
`endif

    for (int n = 0; n < 20; n++) begin
`ifdef SERIAL_ADD_SUB_EN
      run8(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), "random");
`else
      run8(8'($urandom), 8'($urandom), 1'($urandom), 1'b0, "random");
`endif
    end

    // exhaustive WIDTH=2, back-to-back at minimum spacing
    for (int v = 0; v < 32; v++) begin
      logic [2:0] exp3;
      logic [4:0] vv;
      vv = 5'(v);
      @(negedge clk);
      start2 = 1'b1; a2 = vv[1:0]; b2 = vv[3:2]; cin2 = vv[4];
      exp3 = {1'b0, vv[1:0]} + {1'b0, vv[3:2]} + {2'b00, vv[4]};
      @(posedge clk);
      @(negedge clk);
      start2 = 1'b0;
      chk("w2 busy", {busy2, done2}, 2'b10);
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("w2 done", {busy2, done2}, 2'b01);
      chk("w2 result", {cout2, sum2}, exp3);
      @(posedge clk);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
